// File: rtl/sha256_round_logic.sv
// SHA-256 round helper: bitwise Choice/Majority functions plus a clearable
// address counter that walks the H-value and message/K-constant buses.
module sha256_round_logic #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CNT_CLR,
  output logic [CW-1:0] CNT,
  input  logic [DW-1:0] E,
  input  logic [DW-1:0] F,
  input  logic [DW-1:0] G,
  output logic [DW-1:0] CH,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] C,
  output logic [DW-1:0] MAJ
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Per-bit Ch/Maj; kept in the XOR form so t1/t2 logic maps to plain LUTs.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_bitfn
      assign CH[gi]  = (E[gi] & F[gi]) ^ (~E[gi] & G[gi]);
      assign MAJ[gi] = (A[gi] & B[gi]) ^ (A[gi] & C[gi]) ^ (B[gi] & C[gi]);
    end
  endgenerate

  // Clear wins over increment; the increment wraps silently at 2^CW.
  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (CNT_CLR) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign CNT = cnt_reg;

endmodule

// File: tb/tb_sha256_round_logic.sv
// Scoreboard bench for sha256_round_logic: stimulus pushes expected values,
// a negedge monitor pops and compares CNT, CH and MAJ.
module tb_sha256_round_logic;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          CLK;
  logic          RST_N;
  logic          CNT_CLR;
  logic [CW-1:0] CNT;
  logic [DW-1:0] E, F, G, A, B, C;
  logic [DW-1:0] CH, MAJ;

  sha256_round_logic #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CNT_CLR(CNT_CLR), .CNT(CNT),
    .E(E), .F(F), .G(G), .CH(CH),
    .A(A), .B(B), .C(C), .MAJ(MAJ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [7:0]  cnt;
    logic [31:0] ch;
    logic [31:0] maj;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   txn_id = 0;
  int   model_cnt = 0;
  bit   stim_done = 0;

  function automatic logic [31:0] ref_ch(input logic [31:0] e, f, g);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = e[i] ? f[i] : g[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_maj(input logic [31:0] a, b, c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    return r;
  endfunction

  // One clock: update the counter model at the edge, then drive the next inputs
  // 1 time unit later; a reset applied here must show up before the next edge.
  task automatic cycle(input bit clr, input bit rstn,
                       input logic [31:0] e, f, g, a, b, c,
                       input bit kat, input logic [31:0] kch, kmaj);
    exp_t x;
    @(posedge CLK);
    if (!RST_N) model_cnt = 0;
    else if (CNT_CLR) model_cnt = 0;
    else model_cnt = (model_cnt + 1) % 256;
    #1;
    CNT_CLR = clr;
    RST_N   = rstn;
    E = e; F = f; G = g; A = a; B = b; C = c;
    if (!rstn) model_cnt = 0;
    x.id  = txn_id++;
    x.cnt = 8'(model_cnt);
    x.ch  = kat ? kch  : ref_ch(e, f, g);
    x.maj = kat ? kmaj : ref_maj(a, b, c);
    sb.push_back(x);
  endtask

  task automatic rcycle(input bit clr, input bit rstn);
    cycle(clr, rstn, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          1'b0, 32'h0, 32'h0);
  endtask

  task automatic rcycles(input int n, input bit clr, input bit rstn);
    for (int i = 0; i < n; i++) rcycle(clr, rstn);
  endtask

  // Monitor: every cycle the DUT presents CNT/CH/MAJ, compared on the falling edge.
  initial begin
    exp_t t;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        checks += 3;
        $display("txn %0d cnt=%0d ch=%08h maj=%08h", t.id, CNT, CH, MAJ);
        if (CNT !== t.cnt) begin
          failures++;
          $display("FAIL cnt txn %0d: got %0d expected %0d", t.id, CNT, t.cnt);
        end
        if (CH !== t.ch) begin
          failures++;
          $display("FAIL ch txn %0d: got %08h expected %08h", t.id, CH, t.ch);
        end
        if (MAJ !== t.maj) begin
          failures++;
          $display("FAIL maj txn %0d: got %08h expected %08h", t.id, MAJ, t.maj);
        end
      end
    end
  end

  initial begin
    logic [31:0] x;
    RST_N = 1'b0; CNT_CLR = 1'b1;
    E = '0; F = '0; G = '0; A = '0; B = '0; C = '0;

    // Reset held: counter 0, Ch/Maj follow inputs; known-answer vectors.
    rcycles(2, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab,
          32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 1'b1, 32'h1f85c98c, 32'h3a6fe667);
    x = $urandom;
    cycle(1'b1, 1'b0, 32'hffffffff, x, $urandom, 32'hffffffff, 32'h0, x,
          1'b1, x, x);
    x = $urandom;
    cycle(1'b1, 1'b0, 32'h0, $urandom, x, 32'h0, 32'h0, $urandom,
          1'b1, x, 32'h0);
    cycle(1'b1, 1'b0, 32'h0000ffff, 32'h12345678, 32'h9abcdef0,
          32'hffffffff, 32'hffffffff, 32'h0, 1'b1, 32'h9abc5678, 32'hffffffff);

    // Release reset with clear held for two edges, then load run to 8.
    rcycles(2, 1'b1, 1'b1);
    rcycles(8, 1'b0, 1'b1);
    rcycles(3, 1'b1, 1'b1);

    // Hash-length run, then full wrap.
    rcycles(63, 1'b0, 1'b1);
    rcycle(1'b1, 1'b1);
    rcycles(257, 1'b0, 1'b1);

    // Async reset at 37, held through edges, released with clear low.
    rcycle(1'b1, 1'b1);
    rcycles(37, 1'b0, 1'b1);
    rcycles(3, 1'b0, 1'b0);
    rcycles(3, 1'b0, 1'b1);

    // Clear priority at 200.
    rcycle(1'b1, 1'b1);
    rcycles(200, 1'b0, 1'b1);
    rcycle(1'b1, 1'b1);
    rcycle(1'b0, 1'b1);
    rcycle(1'b1, 1'b1);

    // Random mix of clear and occasional reset.
    for (int i = 0; i < 200; i++)
      rcycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) != 0));

    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 20000) begin
      @(posedge CLK);
      guard++;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    checks++;
    if (!stim_done || sb.size() != 0) begin
      failures++;
      $display("FAIL drain: stim_done=%0d pending=%0d expected done with 0 pending",
               stim_done, sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
